// File: rtl/ccu_clear_seq.sv
// rtl/ccu_clear_seq.sv - clear-gate sequencer: arms on r2/s2 orders, opens per-tank
// active-low clear gates for CLR_CYCLES minor cycles, then issues one end pulse.
module ccu_clear_seq #(
  parameter int NUM_TANKS  = 3,
  parameter int CLR_CYCLES = 1,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ev_d0,
  input  logic                 odd_d0,
  input  logic                 r2,
  input  logic                 s2,
  input  logic                 c_store,
  input  logic                 c_load,
  input  logic                 retain,
  input  logic [NUM_TANKS-1:0] clr_sel,
  output logic [NUM_TANKS-1:0] g_clr_neg,
  output logic                 g_any_neg,
  output logic                 ep_clear,
  output logic                 ep_retain,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CLEAR} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_TANKS-1:0] sel_q, sel_d;
  logic                 ret_q, ret_d;
  logic                 ovr_q, ovr_d;
  logic                 ep_clear_q, ep_clear_d;
  logic                 ep_retain_q, ep_retain_d;
  logic [NUM_TANKS-1:0] g_clr_neg_q;
  logic                 g_any_neg_q;
  logic                 busy_q;
  logic                 arm;

  assign arm = (r2 & c_store) | (s2 & c_load);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ret_d       = ret_q;
    ovr_d       = ovr_q | (arm & (state_q != S_IDLE));
    ep_clear_d  = 1'b0;
    ep_retain_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          ret_d   = retain;
          sel_d   = retain ? '0 : clr_sel;
        end
      end
      S_ARMED: begin
        // odd_d0 wins over a coincident ev_d0 here: the window only starts now
        if (odd_d0) begin
          state_d = S_CLEAR;
          cnt_d   = CNT_W'(CLR_CYCLES);
        end
      end
      S_CLEAR: begin
        if (ev_d0) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d     = S_IDLE;
            ep_retain_d = ret_q;
            ep_clear_d  = ~ret_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate/busy outputs are flopped from next-state so they align with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      ret_q       <= 1'b0;
      ovr_q       <= 1'b0;
      ep_clear_q  <= 1'b0;
      ep_retain_q <= 1'b0;
      g_clr_neg_q <= '1;
      g_any_neg_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ret_q       <= ret_d;
      ovr_q       <= ovr_d;
      ep_clear_q  <= ep_clear_d;
      ep_retain_q <= ep_retain_d;
      g_clr_neg_q <= ~(sel_d & {NUM_TANKS{state_d == S_CLEAR}});
      g_any_neg_q <= ~(state_d == S_CLEAR);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign g_clr_neg = g_clr_neg_q;
  assign g_any_neg = g_any_neg_q;
  assign ep_clear  = ep_clear_q;
  assign ep_retain = ep_retain_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ccu_clear_seq.sv
// tb/tb_ccu_clear_seq.sv - directed bench for ccu_clear_seq with CLR_CYCLES of 1, 2 and 3.
module tb_ccu_clear_seq;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk, rst_n;
  logic ev_d0, odd_d0, r2, s2, c_store, c_load, retain;
  logic [2:0] clr_sel;
  logic [2:0] g1, g2, g3;
  logic any1, any2, any3, epc1, epc2, epc3, epr1, epr2, epr3;
  logic busy1, busy2, busy3, ovr1, ovr2, ovr3;

  int n_tests = 0;
  int n_fail  = 0;

  ccu_clear_seq #(.NUM_TANKS(3), .CLR_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .ev_d0(ev_d0), .odd_d0(odd_d0), .r2(r2), .s2(s2),
    .c_store(c_store), .c_load(c_load), .retain(retain), .clr_sel(clr_sel),
    .g_clr_neg(g1), .g_any_neg(any1), .ep_clear(epc1), .ep_retain(epr1),
    .busy(busy1), .overrun(ovr1));

  ccu_clear_seq #(.NUM_TANKS(3), .CLR_CYCLES(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .ev_d0(ev_d0), .odd_d0(odd_d0), .r2(r2), .s2(s2),
    .c_store(c_store), .c_load(c_load), .retain(retain), .clr_sel(clr_sel),
    .g_clr_neg(g2), .g_any_neg(any2), .ep_clear(epc2), .ep_retain(epr2),
    .busy(busy2), .overrun(ovr2));

  ccu_clear_seq #(.NUM_TANKS(3), .CLR_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .ev_d0(ev_d0), .odd_d0(odd_d0), .r2(r2), .s2(s2),
    .c_store(c_store), .c_load(c_load), .retain(retain), .clr_sel(clr_sel),
    .g_clr_neg(g3), .g_any_neg(any3), .ep_clear(epc3), .ep_retain(epr3),
    .busy(busy3), .overrun(ovr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic ev, odd, r2, s2, cs, cl, ret;
    logic [2:0] sel;
    logic [2:0] g;
    logic any, epc, epr, busy, ovr;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ev_d0 = 0; odd_d0 = 0; r2 = 0; s2 = 0; c_store = 0; c_load = 0; retain = 0; clr_sel = 3'b000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_u(input string name, input logic [2:0] g, input logic any, input logic epc,
                       input logic epr, input logic busy, input logic ovr,
                       input logic [2:0] ag, input logic aany, input logic aepc,
                       input logic aepr, input logic abusy, input logic aovr);
    chk({name, ".g_clr_neg"}, 32'(ag), 32'(g));
    chk({name, ".g_any_neg"}, 32'(aany), 32'(any));
    chk({name, ".ep_clear"}, 32'(aepc), 32'(epc));
    chk({name, ".ep_retain"}, 32'(aepr), 32'(epr));
    chk({name, ".busy"}, 32'(abusy), 32'(busy));
    chk({name, ".overrun"}, 32'(aovr), 32'(ovr));
  endtask

  int ep_seen;

  initial begin
    //          ev odd r2 s2 cs cl ret sel      g       any epc epr busy ovr
    tv[0]  = '{L, L, H, L, H, L, L, 3'b001, 3'b111, H, L, L, H, L};  // T order arm
    tv[1]  = '{L, H, L, L, L, L, L, 3'b000, 3'b110, L, L, L, H, L};
    tv[2]  = '{L, L, L, L, L, L, L, 3'b000, 3'b110, L, L, L, H, L};
    tv[3]  = '{H, L, L, L, L, L, L, 3'b000, 3'b111, H, H, L, L, L};
    tv[4]  = '{L, L, L, L, L, L, L, 3'b000, 3'b111, H, L, L, L, L};
    tv[5]  = '{L, L, H, L, H, L, H, 3'b111, 3'b111, H, L, L, H, L};  // U order
    tv[6]  = '{L, H, L, L, L, L, L, 3'b000, 3'b111, L, L, L, H, L};
    tv[7]  = '{H, L, L, L, L, L, L, 3'b000, 3'b111, H, L, H, L, L};
    tv[8]  = '{L, L, L, L, L, L, L, 3'b000, 3'b111, H, L, L, L, L};
    tv[9]  = '{L, L, L, H, L, H, L, 3'b010, 3'b111, H, L, L, H, L};  // H order
    tv[10] = '{H, H, L, L, L, L, L, 3'b000, 3'b101, L, L, L, H, L};  // coincident timing
    tv[11] = '{H, L, L, L, L, L, L, 3'b000, 3'b111, H, H, L, L, L};
    tv[12] = '{L, H, H, L, H, L, L, 3'b100, 3'b111, H, L, L, H, L};  // odd with arm ignored
    tv[13] = '{L, L, L, L, L, L, L, 3'b000, 3'b111, H, L, L, H, L};
    tv[14] = '{L, H, L, L, L, L, L, 3'b000, 3'b011, L, L, L, H, L};
    tv[15] = '{H, L, H, L, H, L, L, 3'b001, 3'b111, H, H, L, L, H};  // arm in end-pulse clk
    tv[16] = '{L, L, L, L, L, L, L, 3'b000, 3'b111, H, L, L, L, H};

    idle_in();
    rst_n = 1'b0;
    #12;
    chk_u("reset_u1", 3'b111, H, L, L, L, L, g1, any1, epc1, epr1, busy1, ovr1);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      ev_d0 = tv[i].ev; odd_d0 = tv[i].odd; r2 = tv[i].r2; s2 = tv[i].s2;
      c_store = tv[i].cs; c_load = tv[i].cl; retain = tv[i].ret; clr_sel = tv[i].sel;
      step();
      chk_u($sformatf("vec%0d", i), tv[i].g, tv[i].any, tv[i].epc, tv[i].epr, tv[i].busy,
            tv[i].ovr, g1, any1, epc1, epr1, busy1, ovr1);
    end
    idle_in();

    // Three-cycle window on u3
    do_reset();
    s2 = 1; c_load = 1; clr_sel = 3'b110; step(); idle_in();
    odd_d0 = 1; step(); idle_in();
    chk("c3_open.g", 32'(g3), 32'(3'b001));
    chk("c3_open.any", 32'(any3), 32'(L));
    for (int k = 0; k < 2; k++) begin
      ev_d0 = 1; step(); idle_in();
      chk($sformatf("c3_ev%0d.g", k + 1), 32'(g3), 32'(3'b001));
      chk($sformatf("c3_ev%0d.ep", k + 1), 32'(epc3), 32'(L));
      step();
    end
    ev_d0 = 1; step(); idle_in();
    chk("c3_ev3.g", 32'(g3), 32'(3'b111));
    chk("c3_ev3.ep", 32'(epc3), 32'(H));
    chk("c3_ev3.busy", 32'(busy3), 32'(L));
    step();
    chk("c3_after.ep", 32'(epc3), 32'(L));

    // Arm while ARMED on u3: overrun sticks, exactly one end pulse follows
    do_reset();
    r2 = 1; c_store = 1; clr_sel = 3'b111; step();
    clr_sel = 3'b000; step(); idle_in();
    chk("ovr_armed.ovr", 32'(ovr3), 32'(H));
    chk("ovr_armed.any", 32'(any3), 32'(H));
    chk("ovr_armed.busy", 32'(busy3), 32'(H));
    odd_d0 = 1; step(); idle_in();
    chk("ovr_clear.g", 32'(g3), 32'(3'b000));
    ep_seen = 0;
    for (int k = 0; k < 6; k++) begin
      ev_d0 = 1; step(); idle_in();
      ep_seen += int'(epc3) + int'(epr3);
    end
    chk("ovr_one_ep", 32'(ep_seen), 32'd1);
    chk("ovr_sticky", 32'(ovr3), 32'(H));

    // Reset mid-CLEAR on u2 after the first ev_d0
    do_reset();
    r2 = 1; c_store = 1; clr_sel = 3'b011; step(); idle_in();
    odd_d0 = 1; step(); idle_in();
    ev_d0 = 1; step(); idle_in();
    chk("rst_mid.pre_g", 32'(g2), 32'(3'b100));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.g", 32'(g2), 32'(3'b111));
    chk("rst_mid.any", 32'(any2), 32'(H));
    chk("rst_mid.busy", 32'(busy2), 32'(L));
    step();
    rst_n = 1'b1;
    ep_seen = 0;
    for (int k = 0; k < 4; k++) begin
      ev_d0 = 1; step(); idle_in();
      ep_seen += int'(epc2) + int'(epr2);
    end
    chk("rst_mid.no_ep", 32'(ep_seen), 32'd0);
    chk("rst_mid.busy_after", 32'(busy2), 32'(L));
    chk("rst_mid.ovr", 32'(ovr2), 32'(L));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
